// File: rtl/calc_sequencer.sv
// Sequenced sum/product/net/ratio calculator sharing one adder and one multiplier.
// Ratio runs a restoring divider, one quotient bit per cycle, 2*W cycles.
module calc_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           out_dbz,
  output logic           busy,
  output logic [15:0]    done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SUM   = 2'd0;
  localparam logic [1:0] OP_MUL   = 2'd1;
  localparam logic [1:0] OP_NET   = 2'd2;
  localparam logic [1:0] OP_RATIO = 2'd3;
  localparam int         CNT_W    = $clog2(2*W + 1);

  state_t state, state_next;

  logic [1:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   dividend_q;
  logic [W:0]       divisor_q;
  logic [W+1:0]     rem_q;
  logic [2*W-1:0]   quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   result_q;
  logic             dbz_q;

  logic [W:0]       sum_w;
  logic [2*W-1:0]   prod_w;
  logic [2*W-1:0]   net_w;
  logic [W+2:0]     step_w;
  logic [W+1:0]     rem_next_w;
  logic [2*W-1:0]   quot_next_w;
  logic             last_iter_w;
  logic             accept_w;
  logic             handshake_w;

  // One restoring step: returns {quotient bit, new remainder}. The shifted
  // remainder is always below 2*divisor, so W+2 bits cannot overflow.
  function automatic logic [W+2:0] div_step(input logic [W+1:0] rem,
                                            input logic         msb,
                                            input logic [W:0]   divisor);
    logic [W+1:0] rem_sh;
    logic [W+1:0] div_ext;
    rem_sh  = {rem[W:0], msb};
    div_ext = {1'b0, divisor};
    if (rem_sh >= div_ext) begin
      div_step = {1'b1, rem_sh - div_ext};
    end else begin
      div_step = {1'b0, rem_sh};
    end
  endfunction

  assign sum_w       = {1'b0, a_q} + {1'b0, b_q};
  assign prod_w      = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign net_w       = {{(W-1){1'b0}}, sum_w} + prod_w;
  assign step_w      = div_step(rem_q, dividend_q[2*W-1], divisor_q);
  assign rem_next_w  = step_w[W+1:0];
  assign quot_next_w = {quot_q[2*W-2:0], step_w[W+2]};
  assign last_iter_w = (cnt_q == CNT_W'(1));
  assign accept_w    = (state == IDLE) && in_valid;
  assign handshake_w = (state == DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done_count <= '0;
    end else begin
      state <= state_next;
      if (handshake_w) begin
        done_count <= done_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if ((op_q == OP_RATIO) && (sum_w != '0)) begin
          state_next = DIV;
        end else begin
          state_next = DONE;
        end
      end
      DIV: begin
        if (last_iter_w) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and divider state; never observed before being loaded.
  always_ff @(posedge clk) begin
    if (accept_w) begin
      op_q <= in_op;
      a_q  <= in_a;
      b_q  <= in_b;
    end
    if ((state == EXEC) && (op_q == OP_RATIO)) begin
      dividend_q <= prod_w;
      divisor_q  <= sum_w;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= CNT_W'(2*W);
    end else if (state == DIV) begin
      dividend_q <= {dividend_q[2*W-2:0], 1'b0};
      rem_q      <= rem_next_w;
      quot_q     <= quot_next_w;
      cnt_q      <= cnt_q - CNT_W'(1);
    end
  end

  // Result register: written in EXEC or on the last divide step, held in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (state == EXEC) begin
      case (op_q)
        OP_SUM: begin
          result_q <= {{(W-1){1'b0}}, sum_w};
          dbz_q    <= 1'b0;
        end
        OP_MUL: begin
          result_q <= prod_w;
          dbz_q    <= 1'b0;
        end
        OP_NET: begin
          result_q <= net_w;
          dbz_q    <= 1'b0;
        end
        default: begin
          if (sum_w == '0) begin
            result_q <= '1;
            dbz_q    <= 1'b1;
          end else begin
            dbz_q    <= 1'b0;
          end
        end
      endcase
    end else if ((state == DIV) && last_iter_w) begin
      result_q <= quot_next_w;
    end
  end

  assign out_result = result_q;
  assign out_dbz    = dbz_q;

endmodule
